// File: rtl/osd_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : osd_wr_arbiter
//  Description : Two-requester arbiter for the single OSD write port.
//                Round-robin with a starvation override, optional gating by
//                the OSD-safe window, and a forced idle gap between writes.
//                Requester 0 is the NIOS II write path, requester 1 the
//                hardware status-overlay engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module osd_wr_arbiter #(
   parameter int DW         = 20,
   parameter int GAP_CYC    = 2,
   parameter int USE_WINDOW = 1
) (
   input  logic          SYS_CLK,
   input  logic          SYS_RST,
   input  logic          win_i,
   input  logic [1:0]    req_i,
   input  logic [DW-1:0] data0_i,
   input  logic [DW-1:0] data1_i,
   output logic [1:0]    gnt_o,
   output logic [DW:0]   OSDWr_o,
   output logic          busy_o,
   output logic [1:0]    starve_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Gap counter load value; GAP_CYC is limited to 0..15 so 4 bits suffice.
   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYC);
   localparam logic       GAP_EN   = (GAP_CYC != 0);
   localparam logic       WIN_EN   = (USE_WINDOW != 0);

   state_t        state_q, state_d;
   logic [3:0]    gcnt_q, gcnt_d;
   logic          last_q, last_d;
   logic [1:0]    gnt_q, gnt_d;
   logic          strb_q, strb_d;
   logic [DW-1:0] word_q, word_d;

   logic [1:0]    starve;
   logic [1:0]    starve_req;
   logic          req_ok;
   logic          winner;

   // Per-requester wait counters: count ungranted cycles while requesting,
   // saturate at 255, and clear on grant or when the request is withdrawn.
   for (genvar gi = 0; gi < 2; gi++) begin : g_wcnt
      logic [7:0] wcnt_q;

      // Wait counter update for requester gi.
      always_ff @(posedge SYS_CLK) begin
         if (SYS_RST || !req_i[gi] || gnt_q[gi]) begin
            wcnt_q <= 8'd0;
         end else if (wcnt_q != 8'hFF) begin
            wcnt_q <= wcnt_q + 8'd1;
         end
      end

      assign starve[gi] = (wcnt_q == 8'hFF);
   end

   // A request is grantable only when the window is open (or ignored).
   assign req_ok = (|req_i) && (win_i || !WIN_EN);

   // Winner selection: lone starving requester, then lone requester,
   // otherwise the requester that was not served last.
   always_comb begin
      starve_req = starve & req_i;
      winner     = ~last_q;
      if (starve_req == 2'b01) begin
         winner = 1'b0;
      end else if (starve_req == 2'b10) begin
         winner = 1'b1;
      end else if (req_i == 2'b01) begin
         winner = 1'b0;
      end else if (req_i == 2'b10) begin
         winner = 1'b1;
      end
   end

   // Next-state and registered-output logic; grants only leave ST_IDLE, so
   // the stale request seen during ST_WRITE can never be granted twice.
   always_comb begin
      state_d = state_q;
      gcnt_d  = gcnt_q;
      last_d  = last_q;
      gnt_d   = 2'b00;
      strb_d  = 1'b0;
      word_d  = word_q;
      case (state_q)
         ST_IDLE: begin
            if (req_ok) begin
               state_d = ST_WRITE;
               gnt_d   = winner ? 2'b10 : 2'b01;
               strb_d  = 1'b1;
               word_d  = winner ? data1_i : data0_i;
               last_d  = winner;
            end
         end
         ST_WRITE: begin
            if (GAP_EN) begin
               state_d = ST_GAP;
               gcnt_d  = GAP_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GAP: begin
            gcnt_d = gcnt_q - 4'd1;
            if (gcnt_q <= 4'd1) begin
               state_d = ST_IDLE;
               gcnt_d  = 4'd0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gcnt_d  = 4'd0;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight grant.
   always_ff @(posedge SYS_CLK) begin
      if (SYS_RST) begin
         state_q <= ST_IDLE;
         gcnt_q  <= 4'd0;
         last_q  <= 1'b1;
         gnt_q   <= 2'b00;
         strb_q  <= 1'b0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         gcnt_q  <= gcnt_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         strb_q  <= strb_d;
         word_q  <= word_d;
      end
   end

   assign gnt_o    = gnt_q;
   assign OSDWr_o  = {strb_q, word_q};
   assign busy_o   = (state_q != ST_IDLE);
   assign starve_o = starve;

endmodule
`default_nettype wire

// File: tb/tb_osd_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_osd_wr_arbiter
//  Description : Self-checking bench for osd_wr_arbiter. Two instances share
//                the stimulus: default parameters, and GAP_CYC=0 with the
//                window ignored. A cycle-level reference model checks both.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_osd_wr_arbiter;

   logic        clk;
   logic        rst;
   logic        win;
   logic [1:0]  req;
   logic [19:0] d0, d1;

   logic [1:0]  gntA, gntB;
   logic [20:0] wrA, wrB;
   logic        busyA, busyB;
   logic [1:0]  stvA, stvB;

   int n_cmp = 0;
   int n_err = 0;

   osd_wr_arbiter dut (
      .SYS_CLK (clk),
      .SYS_RST (rst),
      .win_i   (win),
      .req_i   (req),
      .data0_i (d0),
      .data1_i (d1),
      .gnt_o   (gntA),
      .OSDWr_o (wrA),
      .busy_o  (busyA),
      .starve_o(stvA)
   );

   osd_wr_arbiter #(.DW(20), .GAP_CYC(0), .USE_WINDOW(0)) dut_g0 (
      .SYS_CLK (clk),
      .SYS_RST (rst),
      .win_i   (win),
      .req_i   (req),
      .data0_i (d0),
      .data1_i (d1),
      .gnt_o   (gntB),
      .OSDWr_o (wrB),
      .busy_o  (busyB),
      .starve_o(stvB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: "cool" is the number of remaining busy cycles after a
   // write; wait counts are plain integers.
   typedef struct {
      logic [1:0]  gnt;
      logic        strb;
      logic [19:0] word;
      bit          last;
      int          cool;
      int          wc0;
      int          wc1;
   } model_t;

   model_t mA, mB;

   function automatic model_t step(model_t m, bit r, bit w_in, logic [1:0] rq,
                                   logic [19:0] a0, logic [19:0] a1, int gap, bit usewin);
      model_t n = m;
      bit [1:0] st;
      int w;
      if (r) begin
         n.gnt = 0; n.strb = 0; n.word = 0; n.last = 1; n.cool = 0; n.wc0 = 0; n.wc1 = 0;
         return n;
      end
      st = {m.wc1 == 255, m.wc0 == 255} & rq;
      n.wc0 = (rq[0] && !m.gnt[0]) ? ((m.wc0 < 255) ? m.wc0 + 1 : 255) : 0;
      n.wc1 = (rq[1] && !m.gnt[1]) ? ((m.wc1 < 255) ? m.wc1 + 1 : 255) : 0;
      n.gnt = 0;
      n.strb = 0;
      if (m.cool > 0) begin
         n.cool = m.cool - 1;
      end else if (rq != 0 && (w_in || !usewin)) begin
         if (st == 2'b01)       w = 0;
         else if (st == 2'b10)  w = 1;
         else if (rq == 2'b01)  w = 0;
         else if (rq == 2'b10)  w = 1;
         else                   w = m.last ? 0 : 1;
         n.gnt  = (w == 1) ? 2'b10 : 2'b01;
         n.strb = 1;
         n.word = (w == 1) ? a1 : a0;
         n.last = (w == 1);
         n.cool = 1 + gap;
      end
      return n;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // One clock: update models with the inputs present at the edge, then
   // compare both instances against them on the falling edge.
   task automatic tick();
      @(posedge clk);
      mA = step(mA, rst, win, req, d0, d1, 2, 1'b1);
      mB = step(mB, rst, win, req, d0, d1, 0, 1'b0);
      @(negedge clk);
      chk("A.gnt",    32'(gntA),  32'(mA.gnt));
      chk("A.wr",     32'(wrA),   32'({mA.strb, mA.word}));
      chk("A.busy",   32'(busyA), 32'(mA.cool > 0));
      chk("A.starve", 32'(stvA),  32'({mA.wc1 == 255, mA.wc0 == 255}));
      chk("B.gnt",    32'(gntB),  32'(mB.gnt));
      chk("B.wr",     32'(wrB),   32'({mB.strb, mB.word}));
      chk("B.busy",   32'(busyB), 32'(mB.cool > 0));
      chk("B.starve", 32'(stvB),  32'({mB.wc1 == 255, mB.wc0 == 255}));
   endtask

   typedef struct {
      bit          rst;
      bit          win;
      logic [1:0]  req;
      logic [19:0] d0;
      logic [19:0] d1;
      logic [1:0]  gnt;
      logic [20:0] wr;
      bit          busy;
   } vec_t;

   function automatic vec_t v(bit r, bit w, logic [1:0] rq, logic [19:0] a0, logic [19:0] a1,
                              logic [1:0] g, logic [20:0] o, bit b);
      vec_t x;
      x.rst = r; x.win = w; x.req = rq; x.d0 = a0; x.d1 = a1;
      x.gnt = g; x.wr = o; x.busy = b;
      return x;
   endfunction

   vec_t tbl[21];

   initial begin
      // Expected outputs of the default instance after the edge that
      // samples each row's inputs.
      tbl[0]  = v(1, 1, 2'b00, 20'h00000, 20'h00000, 2'b00, 21'h000000, 0);
      tbl[1]  = v(0, 1, 2'b01, 20'h0A5A5, 20'h00000, 2'b01, 21'h10A5A5, 1);
      tbl[2]  = v(0, 1, 2'b00, 20'h0A5A5, 20'h00000, 2'b00, 21'h00A5A5, 1);
      tbl[3]  = v(0, 1, 2'b00, 20'h0A5A5, 20'h00000, 2'b00, 21'h00A5A5, 1);
      tbl[4]  = v(0, 1, 2'b00, 20'h0A5A5, 20'h00000, 2'b00, 21'h00A5A5, 0);
      tbl[5]  = v(1, 1, 2'b11, 20'h11111, 20'h22222, 2'b00, 21'h000000, 0);
      tbl[6]  = v(0, 1, 2'b11, 20'h11111, 20'h22222, 2'b01, 21'h111111, 1);
      tbl[7]  = v(0, 1, 2'b11, 20'h33333, 20'h22222, 2'b00, 21'h011111, 1);
      tbl[8]  = v(0, 1, 2'b11, 20'h33333, 20'h22222, 2'b00, 21'h011111, 1);
      tbl[9]  = v(0, 1, 2'b11, 20'h33333, 20'h22222, 2'b00, 21'h011111, 0);
      tbl[10] = v(0, 1, 2'b11, 20'h33333, 20'h22222, 2'b10, 21'h122222, 1);
      tbl[11] = v(0, 1, 2'b11, 20'h33333, 20'h44444, 2'b00, 21'h022222, 1);
      tbl[12] = v(0, 1, 2'b11, 20'h33333, 20'h44444, 2'b00, 21'h022222, 1);
      tbl[13] = v(0, 1, 2'b11, 20'h33333, 20'h44444, 2'b00, 21'h022222, 0);
      tbl[14] = v(0, 1, 2'b11, 20'h33333, 20'h44444, 2'b01, 21'h133333, 1);
      tbl[15] = v(0, 0, 2'b10, 20'h33333, 20'h55555, 2'b00, 21'h033333, 1);
      tbl[16] = v(0, 0, 2'b10, 20'h33333, 20'h55555, 2'b00, 21'h033333, 1);
      tbl[17] = v(0, 0, 2'b10, 20'h33333, 20'h55555, 2'b00, 21'h033333, 0);
      tbl[18] = v(0, 0, 2'b10, 20'h33333, 20'h55555, 2'b00, 21'h033333, 0);
      tbl[19] = v(0, 1, 2'b10, 20'h33333, 20'h55555, 2'b10, 21'h155555, 1);
      tbl[20] = v(0, 0, 2'b00, 20'h33333, 20'h55555, 2'b00, 21'h055555, 1);

      rst = 1'b1; win = 1'b0; req = 2'b00; d0 = '0; d1 = '0;
      mA = '{gnt: 0, strb: 0, word: 0, last: 1, cool: 0, wc0: 0, wc1: 0};
      mB = mA;

      // Directed table: single request, tie round-robin, window gating.
      for (int i = 0; i < 21; i++) begin
         rst = tbl[i].rst; win = tbl[i].win; req = tbl[i].req;
         d0 = tbl[i].d0; d1 = tbl[i].d1;
         tick();
         chk($sformatf("tbl%0d.gnt", i),  32'(gntA),  32'(tbl[i].gnt));
         chk($sformatf("tbl%0d.wr", i),   32'(wrA),   32'(tbl[i].wr));
         chk($sformatf("tbl%0d.busy", i), 32'(busyA), 32'(tbl[i].busy));
      end

      // Starvation: requester 1 waits with the window closed.
      rst = 1'b1; req = 2'b00; tick();
      rst = 1'b0; win = 1'b0; req = 2'b10; d1 = 20'h0ABCD; d0 = 20'h01234;
      for (int k = 1; k <= 300; k++) begin
         tick();
         if (k == 254) chk("starve254", 32'(stvA), 32'(2'b00));
         if (k == 255) chk("starve255", 32'(stvA), 32'(2'b10));
      end
      chk("starve300", 32'(stvA), 32'(2'b10));
      chk("closed.gnt", 32'(gntA), 32'(2'b00));
      win = 1'b1; req = 2'b11; tick();
      chk("starve.win", 32'(gntA), 32'(2'b10));
      chk("starve.wr",  32'(wrA),  32'(21'h10ABCD));
      req = 2'b01;
      for (int k = 1; k <= 4; k++) tick();
      chk("starve.next", 32'(gntA), 32'(2'b01));

      // Reset asserted during the strobe cycle, request held across it.
      rst = 1'b1; req = 2'b00; tick();
      rst = 1'b0; win = 1'b1; req = 2'b01; d0 = 20'h0F00D; tick();
      chk("rst.pre", 32'(wrA), 32'(21'h10F00D));
      rst = 1'b1; tick();
      chk("rst.gnt",  32'(gntA),  32'(0));
      chk("rst.wr",   32'(wrA),   32'(0));
      chk("rst.busy", 32'(busyA), 32'(0));
      rst = 1'b0; tick();
      chk("rst.regnt", 32'(gntA), 32'(2'b01));
      chk("rst.rewr",  32'(wrA),  32'(21'h10F00D));

      // Zero gap on the second instance: a strobe every other cycle.
      rst = 1'b1; req = 2'b00; tick();
      rst = 1'b0; win = 1'b0; req = 2'b01;
      for (int k = 1; k <= 10; k++) begin
         d0 = 20'(k);
         tick();
         chk($sformatf("gap0.%0d", k), 32'(wrB[20]), 32'(k % 2));
      end

      // Randomized traffic, including occasional resets and withdrawals.
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 99) == 0);
         win = ($urandom_range(0, 3) != 0);
         req = 2'($urandom);
         if ($urandom_range(0, 3) == 0) d0 = 20'($urandom);
         if ($urandom_range(0, 3) == 0) d1 = 20'($urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/osd_wr_arbiter.md
# osd_wr_arbiter

Arbitrates the single OSD write port (strobe plus 20-bit write word) between two requesters in the SYS_CLK domain: the NIOS II write path (requester 0) and a hardware status-overlay engine (requester 1). Writes are issued only inside the OSD-safe window when window gating is enabled. The arbiter uses round-robin with a starvation override, and enforces a minimum idle gap between consecutive writes. It sits between the requesters and the OSD write vector consumed by the PPU.

## Interface
Parameters:
- DW, 20, width of write word (excl. strobe)
- GAP_CYC, 2, idle cycles forced between consecutive writes (0..15)
- USE_WINDOW, 1, 1 = grant only while win_i high; 0 = ignore win_i

Ports:
- SYS_CLK  in  1  system clock
- SYS_RST  in  1  reset; one clock, reset is synchronous and active-high
- win_i  in  1  OSD write window, already synchronous to SYS_CLK (resynced OSD vsync)
- req_i  in  2  write requests; bit i = requester i; level, held until granted
- data0_i  in  DW  write word of requester 0, stable while req_i[0] high
- data1_i  in  DW  write word of requester 1, stable while req_i[1] high
- gnt_o  out  2  one-cycle grant pulse, coincident with the write strobe
- OSDWr_o  out  DW+1  {strobe, word}; strobe bit DW
- busy_o  out  1  high whenever the FSM is not in ST_IDLE
- starve_o  out  2  requester i has waited 255+ cycles ungranted

## Operation
- FSM states:
  - ST_IDLE → ST_WRITE when a grant is issued.
  - ST_WRITE → ST_GAP if GAP_CYC>0, else ST_IDLE.
  - ST_GAP → ST_IDLE after exactly GAP_CYC cycles (4-bit down-counter).
- Eligibility in ST_IDLE: |req_i & (win_i | !USE_WINDOW). No grant is issued in ST_WRITE or ST_GAP.
- Winner selection, in order:
  1. The single starving requester.
  2. The single requesting requester.
  3. Both requesting: the requester not served last (last_q).
- Winner w, at the clock edge:
  - gnt_o[w]<=1.
  - OSDWr_o<={1'b1,data_w_i}.
  - last_q<=w.
  - state<=ST_WRITE.
- Outside the ST_WRITE cycle:
  - Strobe bit and gnt_o are 0.
  - OSDWr_o[DW-1:0] holds the last written word.
- Requester protocol: sample gnt_o high at edge, then drop req or present the next word at that same edge. ST_WRITE absorbs the stale-request cycle, so no double grant.
- Window is checked only at the grant decision. A granted write completes even if win_i falls in the same cycle.
- Wait counters:
  - wcnt[i] is 8-bit and saturates at 255.
  - Increments each cycle req_i[i]=1 and gnt_o[i]=0.
  - Clears on gnt_o[i] or when req_i[i]=0.
  - starve_o[i] = (wcnt[i]==255).
- Both starving: round-robin via last_q.
- Withdrawn request (req drops before grant): no write, counter clears.

## Timing
- Reset values:
  - gnt_o=0, OSDWr_o=0, busy_o=0, starve_o=0.
  - state=ST_IDLE, last_q=1 (requester 0 wins first tie), wcnt=0, gap counter=0.
- Latency: eligible request sampled in cycle n → strobe/gnt high in cycle n+1 (one cycle).
- Throughput: one write per 2+GAP_CYC cycles at most (default 4).
- busy_o: high during ST_WRITE and ST_GAP; low in ST_IDLE.
- Reset mid-operation:
  - Any pending or in-flight grant is dropped; strobe is low from the next cycle.
  - Requesters keep req high and are re-granted normally after reset releases.
- Simultaneous request arrival on an idle arbiter with last_q=0: requester 1 wins; requester 0 is served next (after the gap).
- win_i low with pending requests: FSM stays in ST_IDLE, and wait counters keep counting.

## Test plan
- Single request: reset, win_i=1, req_i=2'b01, data0_i=20'h0A5A5 → cycle+1: OSDWr_o=21'h10A5A5, gnt_o=01, then busy_o high 3 cycles, no second write.
- Tie round-robin: req_i=2'b11 held, re-presented after each grant, GAP_CYC=2 → grants 01,10,01,10, strobes exactly 4 cycles apart.
- Window gating: USE_WINDOW=1, win_i=0, req_i=2'b10 for 50 cycles → no strobe; win_i=1 → strobe next cycle with data1_i; win_i dropped in the grant cycle → write still completes.
- Starvation: req_i[1] held while win_i=0 for 300 cycles → starve_o=2'b10 from cycle 255; win_i=1 with req_i=2'b11 and last_q=1 → requester 1 granted first.
- Reset mid-operation: assert SYS_RST in the strobe cycle → next cycle all outputs 0; release with req_i=2'b01 held → regrant after one cycle.
- GAP_CYC=0: req_i=2'b01 continuously re-presented → strobe every 2nd cycle, never on consecutive cycles.
